// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter sharing one memory controller
// command port between the CPU core (port 0) and the loader/DMA engine
// (port 1). One transaction at a time: grant, one-cycle command, fixed read
// latency, then a one-cycle ack back to the owning port.
module mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic                  arb_clk,
    input  logic                  arb_reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wr_data,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rd_data,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wr_data,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rd_data,
    input  logic                  mem_busy,
    output logic                  mem_rd_enable,
    output logic                  mem_wr_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  arb_owner
);

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_ISSUE = 4'b0010;
    localparam logic [3:0] ST_WAIT  = 4'b0100;
    localparam logic [3:0] ST_RESP  = 4'b1000;

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    logic [3:0]            state;
    logic [3:0]            cnt;
    logic                  last_grant;
    logic                  lat_we;
    logic                  win_port;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    // Round-robin winner: on a tie the port that was not granted last wins
    always_comb begin
        // NOTE: default assigned first so every path drives win_port and no latch is inferred
        win_port = 1'b0;
        if (m0_req && m1_req) begin
            win_port = ~last_grant;
        end else if (m1_req) begin
            win_port = 1'b1;
        end
    end

    assign win_we   = win_port ? m1_we      : m0_we;
    assign win_addr = win_port ? m1_addr    : m0_addr;
    assign win_data = win_port ? m1_wr_data : m0_wr_data;

    // Transaction FSM; every output is a flop updated here
    always_ff @(posedge arb_clk or posedge arb_reset) begin
        if (arb_reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            last_grant    <= 1'b1;
            lat_we        <= 1'b0;
            arb_owner     <= 1'b0;
            mem_rd_enable <= 1'b0;
            mem_wr_enable <= 1'b0;
            mem_addr      <= '0;
            mem_wr_data   <= '0;
            m0_ack        <= 1'b0;
            m1_ack        <= 1'b0;
            // NOTE: the per-port read-data registers are ordinary flops, so they take the reset too and read 0 afterwards
            m0_rd_data    <= '0;
            m1_rd_data    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop sees pre-edge values regardless of statement order
            mem_rd_enable <= 1'b0;
            mem_wr_enable <= 1'b0;
            m0_ack        <= 1'b0;
            m1_ack        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if ((m0_req || m1_req) && !mem_busy) begin
                        arb_owner     <= win_port;
                        lat_we        <= win_we;
                        mem_addr      <= win_addr;
                        mem_wr_data   <= win_data;
                        mem_rd_enable <= ~win_we;
                        mem_wr_enable <= win_we;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= LAT_LOAD;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (!lat_we) begin
                            if (arb_owner) m1_rd_data <= mem_rd_data;
                            else           m0_rd_data <= mem_rd_data;
                        end
                        if (arb_owner) m1_ack <= 1'b1;
                        else           m0_ack <= 1'b1;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    last_grant <= arb_owner;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized stimulus with a transaction-level
// reference model feeding a scoreboard; a separate monitor checks commands,
// acks and read data as the DUT presents them.
module tb_mem_arbiter;

    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int LAT = 2;

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            grant_cyc;
    } txn_t;

    logic          arb_clk = 1'b0;
    logic          arb_reset = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wr_data = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wr_data = '0;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic          mem_busy = 1'b0;
    logic          mem_rd_enable, mem_wr_enable;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data = '0;
    logic          arb_owner;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    txn_t cmd_q[$];
    txn_t ack_q[$];
    int   cmd_log[$];
    int   ack_log[$];
    int   ack_cyc_log[$];

    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] ctl_mem [256];
    logic [DW-1:0] exp_rd [2];
    bit            ref_last = 1'b1;
    int            ref_free = 0;
    int            rd_due = -1;
    logic [DW-1:0] rd_val = '0;
    bit            rand_done = 1'b0;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .arb_clk(arb_clk), .arb_reset(arb_reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
        .mem_busy(mem_busy), .mem_rd_enable(mem_rd_enable), .mem_wr_enable(mem_wr_enable),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .arb_owner(arb_owner)
    );

    always #5 arb_clk = ~arb_clk;

    always @(posedge arb_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: transaction-level arbitration. A grant is possible once
    // the previous transaction's LAT+3 cycle slot has elapsed.
    always @(negedge arb_clk) begin
        txn_t t;
        if (arb_reset) begin
            cmd_q.delete();
            ack_q.delete();
            ref_last = 1'b1;
            ref_free = 0;
        end else if (cyc >= ref_free && (m0_req || m1_req) && !mem_busy) begin
            t.port      = (m0_req && m1_req) ? !ref_last : m1_req;
            t.we        = t.port ? m1_we : m0_we;
            t.addr      = t.port ? m1_addr : m0_addr;
            t.wdata     = t.port ? m1_wr_data : m0_wr_data;
            t.rdata     = ref_mem[t.addr[7:0]];
            t.grant_cyc = cyc;
            if (t.we) ref_mem[t.addr[7:0]] = t.wdata;
            cmd_q.push_back(t);
            ack_q.push_back(t);
            ref_last = t.port;
            ref_free = cyc + LAT + 3;
        end
    end

    // Memory controller model: read data is valid only in the cycle LAT after the pulse
    always @(negedge arb_clk) begin
        if (!arb_reset) begin
            if (mem_rd_enable) begin
                rd_due = cyc + LAT;
                rd_val = ctl_mem[mem_addr[7:0]];
            end
            if (mem_wr_enable) ctl_mem[mem_addr[7:0]] = mem_wr_data;
        end
    end

    always @(posedge arb_clk) begin
        #1;
        mem_rd_data = (cyc == rd_due) ? rd_val : DW'($urandom);
    end

    // Monitor: compares every command pulse and ack against the scoreboard
    always @(negedge arb_clk) begin
        txn_t t;
        if (arb_reset) begin
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else begin
            if (mem_rd_enable || mem_wr_enable) begin
                cmd_log.push_back(cyc);
                if (cmd_q.size() == 0) begin
                    check("unexpected_cmd", {mem_rd_enable, mem_wr_enable}, 0);
                end else begin
                    t = cmd_q.pop_front();
                    check("cmd_cycle", cyc, t.grant_cyc + 1);
                    check("cmd_rd_en", mem_rd_enable, !t.we);
                    check("cmd_wr_en", mem_wr_enable, t.we);
                    check("cmd_addr", mem_addr, t.addr);
                    if (t.we) check("cmd_wr_data", mem_wr_data, t.wdata);
                end
            end
            if (m0_ack || m1_ack) begin
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", {m1_ack, m0_ack}, 0);
                end else begin
                    t = ack_q.pop_front();
                    ack_log.push_back(t.port);
                    ack_cyc_log.push_back(cyc);
                    check("ack_cycle", cyc, t.grant_cyc + 2 + LAT);
                    check("ack_port", {m1_ack, m0_ack}, t.port ? 2'b10 : 2'b01);
                    check("ack_owner", arb_owner, t.port);
                    if (!t.we) exp_rd[t.port] = t.rdata;
                end
            end
            check("m0_rd_data", m0_rd_data, exp_rd[0]);
            check("m1_rd_data", m1_rd_data, exp_rd[1]);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge arb_clk);
            #1;
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            m0_req = r; m0_we = w; m0_addr = a; m0_wr_data = d;
        end else begin
            m1_req = r; m1_we = w; m1_addr = a; m1_wr_data = d;
        end
    endtask

    // Waits for this port's ack; returns in the cycle after it (arbiter back in IDLE)
    task automatic wait_ack(input int p, output int tack);
        bit ok;
        ok = 1'b0;
        tack = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge arb_clk);
            if ((p == 0) ? m0_ack : m1_ack) begin
                ok = 1'b1;
                tack = cyc;
            end
        end
        check("ack_within_budget", ok, 1);
        @(posedge arb_clk);
        #1;
    endtask

    task automatic wait_acks(input int n);
        int start;
        bit got;
        start = ack_log.size();
        got = 1'b0;
        for (int i = 0; i < 100 * n && !got; i++) begin
            @(posedge arb_clk);
            #1;
            if (ack_log.size() >= start + n) got = 1'b1;
        end
        check("acks_within_budget", got, 1);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({m0_ack, m1_ack, m0_rd_data, m1_rd_data, mem_rd_enable, mem_wr_enable,
                    mem_addr, mem_wr_data, arb_owner});
    endfunction

    task automatic agent(input int p, input int ntx);
        int            tack;
        bit            hold;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        hold = 1'b0;
        w = 1'b0;
        a = '0;
        d = '0;
        for (int k = 0; k < ntx; k++) begin
            if (!hold) tick($urandom_range(0, 4));
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 15)) | (AW'($urandom_range(0, 255)) << 8);
            d = DW'($urandom);
            drive(p, 1'b1, w, a, d);
            wait_ack(p, tack);
            hold = ($urandom_range(0, 2) == 0);
            if (!hold) drive(p, 1'b0, w, a, d);
        end
        drive(p, 1'b0, w, a, d);
    endtask

    initial begin
        int t0, tack, n0, ps, b;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = DW'(i * 37 + 11);
            ctl_mem[i] = DW'(i * 37 + 11);
        end
        ref_mem[8'h34] = 8'hA5;
        ctl_mem[8'h34] = 8'hA5;

        // Reset state
        tick(3);
        check("reset_outputs", all_outputs(), 0);
        arb_reset = 1'b0;
        tick(1);

        // Port 0 read at 0x1234
        drive(0, 1'b1, 1'b0, 16'h1234, 8'h00);
        t0 = cyc;
        wait_ack(0, tack);
        drive(0, 1'b0, 1'b0, 16'h1234, 8'h00);
        check("p0_read_ack_latency", tack, t0 + LAT + 2);
        check("p0_read_cmd_cycle", cmd_log[$], t0 + 1);
        check("p0_read_data", m0_rd_data, 8'hA5);
        check("p0_read_m1_untouched", m1_rd_data, 8'h00);

        // Port 1 write of 0x3C to 0x00FF
        drive(1, 1'b1, 1'b1, 16'h00FF, 8'h3C);
        t0 = cyc;
        wait_ack(1, tack);
        drive(1, 1'b0, 1'b1, 16'h00FF, 8'h3C);
        check("p1_write_ack_latency", tack, t0 + LAT + 2);
        check("p1_write_m0_untouched", m0_rd_data, 8'hA5);
        check("p1_write_m1_untouched", m1_rd_data, 8'h00);

        // Fairness: both ports hold requests for six transactions
        ps = ack_log.size();
        drive(0, 1'b1, 1'b0, 16'h0001, 8'h00);
        drive(1, 1'b1, 1'b0, 16'h0002, 8'h00);
        wait_acks(6);
        drive(0, 1'b0, 1'b0, 16'h0001, 8'h00);
        drive(1, 1'b0, 1'b0, 16'h0002, 8'h00);
        if (ack_log.size() >= ps + 6) begin
            for (int i = 0; i < 6; i++) check("fair_port", ack_log[ps + i], i % 2);
            for (int i = 1; i < 6; i++)
                check("fair_spacing", ack_cyc_log[ps + i] - ack_cyc_log[ps + i - 1], LAT + 3);
        end

        // Read back the port 1 write through port 0
        drive(0, 1'b1, 1'b0, 16'h00FF, 8'h00);
        wait_ack(0, tack);
        drive(0, 1'b0, 1'b0, 16'h00FF, 8'h00);
        check("readback_data", m0_rd_data, 8'h3C);

        // Busy gating
        n0 = cmd_log.size();
        mem_busy = 1'b1;
        drive(0, 1'b1, 1'b0, 16'h0010, 8'h00);
        tick(20);
        check("busy_no_cmd", cmd_log.size(), n0);
        mem_busy = 1'b0;
        b = cyc;
        wait_ack(0, tack);
        drive(0, 1'b0, 1'b0, 16'h0010, 8'h00);
        check("busy_release_cmd", cmd_log[$], b + 1);

        // Early drop of m1_req the cycle after its grant
        n0 = ack_log.size();
        drive(1, 1'b1, 1'b0, 16'h0020, 8'h00);
        tick(1);
        drive(1, 1'b0, 1'b0, 16'h0020, 8'h00);
        tick(LAT + 6);
        check("early_drop_ack_count", ack_log.size() - n0, 1);
        if (ack_log.size() > n0) check("early_drop_ack_port", ack_log[$], 1);

        // Reset mid-WAIT abandons the transaction
        drive(0, 1'b1, 1'b0, 16'h0030, 8'h00);
        tick(2);
        drive(0, 1'b0, 1'b0, 16'h0030, 8'h00);
        #2;
        arb_reset = 1'b1;
        #1;
        check("midreset_outputs", all_outputs(), 0);
        tick(2);
        check("midreset_outputs_held", all_outputs(), 0);
        arb_reset = 1'b0;
        n0 = ack_log.size();
        tick(LAT + 6);
        check("midreset_no_ack", ack_log.size() - n0, 0);
        drive(0, 1'b1, 1'b0, 16'h0040, 8'h00);
        drive(1, 1'b1, 1'b0, 16'h0041, 8'h00);
        wait_acks(1);
        drive(0, 1'b0, 1'b0, 16'h0040, 8'h00);
        drive(1, 1'b0, 1'b0, 16'h0041, 8'h00);
        if (ack_log.size() > n0) check("tie_after_reset_port", ack_log[n0], 0);
        tick(LAT + 4);

        // Randomized traffic on both ports with random busy
        fork
            begin
                fork
                    agent(0, 15);
                    agent(1, 15);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge arb_clk);
                    #1;
                    mem_busy = ($urandom_range(0, 3) == 0);
                end
                mem_busy = 1'b0;
            end
        join

        tick(LAT + 6);
        check("cmd_queue_drained", cmd_q.size(), 0);
        check("ack_queue_drained", ack_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
